// File: rtl/led_cmd_sequencer.sv
// Framed UART command parser driving a small LED register with autonomous blinking.
// Frames are A5, CMD, ARG, CHK (CHK = CMD ^ ARG). Commands take effect two edges after CHK.
module led_cmd_sequencer #(
  parameter int NUM_LEDS        = 2,
  parameter int TICK_DIV        = 50000,
  parameter int TIMEOUT_MS      = 10,
  parameter int DEF_HALF_PERIOD = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_LEDS-1:0] leds,
  output logic                cmd_done,
  output logic                frame_err,
  output logic                busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_MS);

  localparam logic [7:0] SOF              = 8'hA5;
  localparam logic [7:0] CMD_SET          = 8'h01;
  localparam logic [7:0] CMD_TOGGLE       = 8'h02;
  localparam logic [7:0] CMD_BLINK_MASK   = 8'h03;
  localparam logic [7:0] CMD_BLINK_PERIOD = 8'h04;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_ARG = 3'd2,
    GET_CHK = 3'd3,
    EXEC    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          cmd_q, arg_q;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [TW-1:0]       timeout_cnt;
  logic                in_frame, timed_out;
  logic                fsm_err, byte_acc, latch_cmd, latch_arg;
  logic [7:0]          blink_cnt, half_period;
  logic [NUM_LEDS-1:0] blink_mask;
  logic                blink_evt, apply_known;
  logic                exec_vld_p0;
  logic [7:0]          exec_cmd_p0, exec_arg_p0;

  function automatic logic [7:0] sat_half_period(input logic [7:0] p);
    return (p == 8'd0) ? 8'd1 : p;
  endfunction

  function automatic logic is_known(input logic [7:0] c);
    return (c == CMD_SET) || (c == CMD_TOGGLE) ||
           (c == CMD_BLINK_MASK) || (c == CMD_BLINK_PERIOD);
  endfunction

  assign tick      = (presc == PRESC_MAX);
  assign in_frame  = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
  assign timed_out = in_frame && (timeout_cnt == TO_LIMIT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     presc <= '0;
    else if (tick)  presc <= '0;
    else            presc <= presc + 1'b1;
  end

  // A timeout wins over a byte arriving in the same cycle, so that byte is dropped.
  always_comb begin
    state_nxt = state;
    fsm_err   = 1'b0;
    byte_acc  = 1'b0;
    latch_cmd = 1'b0;
    latch_arg = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SOF) begin
          state_nxt = GET_CMD;
          byte_acc  = 1'b1;
        end
      end
      GET_CMD: begin
        if (timed_out) begin
          state_nxt = IDLE;
          fsm_err   = 1'b1;
        end else if (rx_valid) begin
          state_nxt = GET_ARG;
          byte_acc  = 1'b1;
          latch_cmd = 1'b1;
        end
      end
      GET_ARG: begin
        if (timed_out) begin
          state_nxt = IDLE;
          fsm_err   = 1'b1;
        end else if (rx_valid) begin
          state_nxt = GET_CHK;
          byte_acc  = 1'b1;
          latch_arg = 1'b1;
        end
      end
      GET_CHK: begin
        if (timed_out) begin
          state_nxt = IDLE;
          fsm_err   = 1'b1;
        end else if (rx_valid) begin
          byte_acc = 1'b1;
          if (rx_data == (cmd_q ^ arg_q)) begin
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
            fsm_err   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (rx_valid && rx_data == SOF) begin
          state_nxt = GET_CMD;
          byte_acc  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Held at zero outside the receive states, so entry to GET_CMD always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         timeout_cnt <= '0;
    else if (byte_acc || !in_frame)                     timeout_cnt <= '0;
    else if (tick && timeout_cnt != TO_LIMIT)           timeout_cnt <= timeout_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (latch_cmd) cmd_q <= rx_data;
    if (latch_arg) arg_q <= rx_data;
  end

  // Stage p0: command captured while EXEC is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exec_vld_p0 <= 1'b0;
    else        exec_vld_p0 <= (state == EXEC);
  end

  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      exec_cmd_p0 <= cmd_q;
      exec_arg_p0 <= arg_q;
    end
  end

  assign apply_known = exec_vld_p0 && is_known(exec_cmd_p0);
  assign blink_evt   = tick && (blink_cnt >= half_period - 8'd1);

  // Stage p1: apply command; a command in the same cycle as a blink event suppresses the toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds        <= '0;
      blink_mask  <= '0;
      half_period <= 8'(DEF_HALF_PERIOD);
      blink_cnt   <= 8'd0;
      cmd_done    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cmd_done  <= apply_known;
      frame_err <= fsm_err || (exec_vld_p0 && !is_known(exec_cmd_p0));
      if (tick) blink_cnt <= blink_evt ? 8'd0 : blink_cnt + 8'd1;
      if (apply_known) begin
        case (exec_cmd_p0)
          CMD_SET:    leds <= exec_arg_p0[NUM_LEDS-1:0];
          CMD_TOGGLE: leds <= leds ^ exec_arg_p0[NUM_LEDS-1:0];
          CMD_BLINK_MASK: begin
            blink_mask <= exec_arg_p0[NUM_LEDS-1:0];
            blink_cnt  <= 8'd0;
          end
          CMD_BLINK_PERIOD: begin
            half_period <= sat_half_period(exec_arg_p0);
            blink_cnt   <= 8'd0;
          end
          default: ;
        endcase
      end else if (blink_evt) begin
        leds <= leds ^ blink_mask;
      end
    end
  end

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Directed plus randomized bench for led_cmd_sequencer with a frame-level reference model.
// The model knows each frame it sends and schedules the resulting effects by edge count.
module tb_led_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] leds;
  logic       cmd_done, frame_err, busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         k;          // edges since reset release
  int         apply_at;   // edge at which a known command takes effect
  int         err_at;     // edge after which frame_err is high
  logic [7:0] apply_cmd, apply_arg;
  logic [1:0] m_leds, m_mask;
  int         m_hp, m_phase;

  led_cmd_sequencer #(
    .NUM_LEDS(2), .TICK_DIV(4), .TIMEOUT_MS(3), .DEF_HALF_PERIOD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .leds(leds), .cmd_done(cmd_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; apply_at = -1; err_at = -1;
    apply_cmd = 8'h00; apply_arg = 8'h00;
    m_leds = 2'b00; m_mask = 2'b00; m_hp = 2; m_phase = 0;
  endtask

  // One clock: drive a byte (or nothing), advance the model by one edge, compare.
  task automatic cycle(input logic v, input logic [7:0] d);
    logic tk, do_cmd, toggle;
    rx_valid = v; rx_data = d;
    @(posedge clk);
    k++;
    tk     = (k % 4 == 0);
    do_cmd = (k == apply_at);
    toggle = 1'b0;
    if (do_cmd && (apply_cmd == 8'h03 || apply_cmd == 8'h04)) m_phase = 0;
    else if (tk) begin
      m_phase++;
      if (m_phase >= m_hp) begin
        m_phase = 0;
        toggle  = !do_cmd;
      end
    end
    if (do_cmd) begin
      case (apply_cmd)
        8'h01: m_leds = apply_arg[1:0];
        8'h02: m_leds = m_leds ^ apply_arg[1:0];
        8'h03: m_mask = apply_arg[1:0];
        default: m_hp = (apply_arg == 8'h00) ? 1 : int'(apply_arg);
      endcase
    end else if (toggle) m_leds = m_leds ^ m_mask;
    #1;
    rx_valid = 1'b0;
    chk("leds", 32'(leds), 32'(m_leds));
    chk("cmd_done", 32'(cmd_done), 32'(do_cmd));
    chk("frame_err", 32'(frame_err), 32'(k == err_at));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] ck,
                            input int gap);
    cycle(1'b1, 8'hA5); idle(gap);
    cycle(1'b1, c);     idle(gap);
    cycle(1'b1, a);     idle(gap);
    if (ck !== (c ^ a)) err_at = k + 1;
    else if (c >= 8'h01 && c <= 8'h04) begin
      apply_at = k + 3; apply_cmd = c; apply_arg = a;
    end else err_at = k + 3;
    cycle(1'b1, ck);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; rx_valid = 1'b0;
    #1;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1;
    apply_reset();

    // 1: SET 3, exact latency and busy window
    cycle(1'b1, 8'hA5); chk("t1_busy_a5", 32'(busy), 32'd1);
    cycle(1'b1, 8'h01); chk("t1_busy_cmd", 32'(busy), 32'd1);
    cycle(1'b1, 8'h03); chk("t1_busy_arg", 32'(busy), 32'd1);
    apply_at = k + 3; apply_cmd = 8'h01; apply_arg = 8'h03;
    cycle(1'b1, 8'h02); chk("t1_busy_exec", 32'(busy), 32'd1);
    cycle(1'b0, 8'h00); chk("t1_busy_idle", 32'(busy), 32'd0);
                        chk("t1_leds_early", 32'(leds), 32'd0);
    cycle(1'b0, 8'h00); chk("t1_leds", 32'(leds), 32'd3);
    idle(3);

    // 2: TOGGLE, then a bad checksum
    send_frame(8'h02, 8'h01, 8'h03, 0); idle(3);
    chk("t2_leds", 32'(leds), 32'd2);
    send_frame(8'h01, 8'h02, 8'h00, 0); idle(3);
    chk("t2_leds_kept", 32'(leds), 32'd2);

    // 3: blink mask 01, half period 3, then 0 -> 1
    send_frame(8'h03, 8'h01, 8'h02, 0);
    send_frame(8'h04, 8'h03, 8'h07, 0);
    idle(40);
    send_frame(8'h04, 8'h00, 8'h04, 1);
    idle(20);

    // 4: truncated frame times out, then a full frame works
    cycle(1'b1, 8'hA5); cycle(1'b1, 8'h01);
    err_at = ((k / 4) + 1) * 4 + 8 + 1;
    chk("t4_timeout_bound", 32'(err_at - k <= 16), 32'd1);
    idle(err_at - k + 1);
    chk("t4_busy_after", 32'(busy), 32'd0);
    send_frame(8'h01, 8'h01, 8'h00, 0);
    cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);
    chk("t4_leds_busy", 32'(busy), 32'd0);
    idle(4);

    // 5: stray bytes in IDLE, then an unknown command
    cycle(1'b1, 8'h00); chk("t5_busy0", 32'(busy), 32'd0);
    cycle(1'b1, 8'hFF); chk("t5_busy1", 32'(busy), 32'd0);
    cycle(1'b1, 8'h5A); chk("t5_busy2", 32'(busy), 32'd0);
    send_frame(8'h07, 8'h00, 8'h07, 0); idle(4);

    // 6: reset mid-blink and mid-frame
    cycle(1'b1, 8'hA5); cycle(1'b1, 8'h02);
    apply_reset();
    idle(20);
    send_frame(8'h01, 8'h01, 8'h00, 0); idle(12);
    send_frame(8'h03, 8'h03, 8'h00, 2); idle(30);

    // randomized frames with stray bytes between them
    for (int f = 0; f < 40; f++) begin
      logic [7:0] c, a, ck, s;
      int sel;
      sel = $urandom_range(0, 5);
      if (sel >= 1 && sel <= 4) c = 8'(sel);
      else c = 8'($urandom_range(5, 255));
      a  = (c == 8'h04) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      ck = c ^ a;
      if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_frame(c, a, ck, $urandom_range(0, 2));
      repeat ($urandom_range(0, 5)) begin
        s = 8'($urandom);
        if (s == 8'hA5) s = 8'h00;
        if ($urandom_range(0, 2) == 0) cycle(1'b1, s);
        else cycle(1'b0, 8'h00);
      end
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
